xcvr_ref_clk_fwd: RTL and testbench
===================================

// Module: xcvr_ref_clk_fwd
// PURPOSE
//  Transmit side of the transceiver reference-clock interface. It synthesises a forwarded reference clock
//  as a 2-slot DDR bit pattern per CLK cycle. The pattern feeds an output DDR register and a differential pad pair.
//  The board partner receives it through its own differential ref-clock input buffer.
//  The block provides glitch-free start/stop and a valid/ready port that reprograms the half-period at a period boundary.
// PARAMETERS
//  CNT_W         8   width of the half-period value, in DDR slots (half CLK cycles)
//  DEFAULT_HALF  4   half-period loaded at reset; must be 1..2^CNT_W-1
// PORTS
//  CLK        in   1      sole clock; all logic rising-edge
//  RESETN     in   1      asynchronous, active-low reset
//  EN         in   1      level: 1 = generate clock, 0 = stop cleanly
//  CFG_VALID  in   1      new half-period offered
//  CFG_HALF   in   CNT_W  requested half-period H in slots
//  CFG_READY  out  1      config holding register empty
//  CFG_ERR    out  1      1-cycle pulse: accepted CFG_HALF was 0 and was dropped
//  DDR_OUT    out  2      [0] = first slot (CLK high half), [1] = second slot; registered
//  RUNNING    out  1      1 in RUN or DRAIN
//  RISE_TICK  out  1      1 on the beat whose DDR_OUT[0] is a period's first high slot
// BEHAVIOUR
//  Reset (async, immediate): state IDLE, DDR_OUT=2'b00, RUNNING=0, RISE_TICK=0, CFG_ERR=0, CFG_READY=1.
//   Reset also sets active H=DEFAULT_HALF, clears the pending config and sets the slot counter to 0.
//  Waveform: H high slots, then H low slots. Period = 2H slots = exactly H CLK cycles.
//   Every period therefore starts on slot 0. Slot counter s runs 0..2H-1. Beat bit i = (s+i < H).
//   s advances by 2 per cycle and wraps to 0 after 2H-2.
//  Latency: the edge that samples EN=1 in IDLE moves to RUN and registers the first beat (s=0, RISE_TICK=1).
//   DDR_OUT is therefore valid one cycle after EN is sampled.
//  States:
//   IDLE: DDR_OUT=00. EN=1 -> RUN.
//   RUN: emit beats. EN=0 sampled -> DRAIN; the beat on that edge is still emitted.
//   DRAIN: continue the current period through its last low beat, then IDLE.
//    If the stopping edge falls exactly on a period boundary, go straight to IDLE with DDR_OUT=00; no partial period.
//    EN re-asserted during DRAIN is ignored until IDLE is reached. If EN is still 1 in IDLE, restart on the next edge.
//  Config handshake: a transfer happens on an edge with CFG_VALID&&CFG_READY.
//   CFG_HALF=0: dropped, CFG_ERR pulses on the next cycle, pending and active H unchanged.
//   Nonzero value in IDLE: written to active H directly; CFG_READY stays 1.
//   Nonzero value in RUN/DRAIN: held in the pending register, CFG_READY=0.
//    The pending value becomes active H at the next period start (s wraps to 0); CFG_READY returns to 1 on that edge.
//   Transfer on the same edge as a wrap: the new H applies to the following period, not the current one.
//  Width: s is CNT_W+1 bits, and the comparisons use CNT_W+1 bits, so H=2^CNT_W-1 cannot overflow.
//  Reset mid-period: output drops to 00 asynchronously. The runt pulse is accepted, because RESETN asserted implies the link is down.
// TESTING
//  1 H=1, EN=1 -> DDR_OUT=01 every cycle, RISE_TICK=1 every cycle, first beat one cycle after EN.
//  2 H=3 -> beats 11,01,00 repeating; RISE_TICK on each 11 beat; period 3 cycles.
//  3 Running at H=2, offer CFG_HALF=5 mid-period -> CFG_READY=0 until the wrap.
//    Then the next period is 11,11,01,00,00 and CFG_READY=1 again.
//  4 H=4, drop EN during the first high beat -> remaining 11,00,00 emitted, then 00 and RUNNING=0.
//    Re-raise EN during DRAIN -> restart only after the IDLE cycle.
//  5 CFG_HALF=0 with CFG_VALID=1 -> CFG_ERR=1 for one cycle; waveform unchanged.
//  6 Assert RESETN=0 mid-high beat -> DDR_OUT=00 without a clock edge.
//    On release: H=DEFAULT_HALF, state IDLE.

Source files
------------

// File: rtl/xcvr_ref_clk_fwd.sv
// Forwarded reference-clock generator: emits H high / H low DDR slots per period as a
// 2-bit beat per CLK cycle, with clean start/stop and period-aligned half-period updates.
module xcvr_ref_clk_fwd #(
    parameter int CNT_W        = 8,
    parameter int DEFAULT_HALF = 4
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             EN,
    input  logic             CFG_VALID,
    input  logic [CNT_W-1:0] CFG_HALF,
    output logic             CFG_READY,
    output logic             CFG_ERR,
    output logic [1:0]       DDR_OUT,
    output logic             RUNNING,
    output logic             RISE_TICK
);
    localparam int SW = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_reg;
    logic [SW-1:0]    slot_reg;
    logic [CNT_W-1:0] half_reg;
    logic [CNT_W-1:0] pend_reg;
    logic             pend_valid_reg;
    logic [1:0]       ddr_reg;
    logic             running_reg;
    logic             rise_reg;
    logic             err_reg;

    logic             cfg_xfer;
    logic             cfg_zero;
    logic             cfg_direct;
    logic             cfg_hold;
    logic [CNT_W-1:0] half_eff;
    logic [SW-1:0]    half_ext;
    logic [SW-1:0]    slot_plus1;
    logic [SW-1:0]    slot_plus2;
    logic [1:0]       beat;
    logic             wrap;
    logic [SW-1:0]    slot_adv;
    logic             stop_now;

    always_comb begin
        cfg_xfer   = CFG_VALID && !pend_valid_reg;
        cfg_zero   = (CFG_HALF == '0);
        cfg_direct = cfg_xfer && !cfg_zero && (state_reg == ST_IDLE);
        cfg_hold   = cfg_xfer && !cfg_zero && (state_reg != ST_IDLE);

        // In IDLE a fresh or still-pending value takes effect for the period about to start.
        half_eff = half_reg;
        if (state_reg == ST_IDLE) begin
            if (cfg_direct)
                half_eff = CFG_HALF;
            else if (pend_valid_reg)
                half_eff = pend_reg;
        end

        half_ext   = {1'b0, half_eff};
        slot_plus1 = slot_reg + SW'(1);
        slot_plus2 = slot_reg + SW'(2);
        beat       = {(slot_plus1 < half_ext), (slot_reg < half_ext)};
        wrap       = (slot_plus2 == {half_eff, 1'b0});
        slot_adv   = wrap ? '0 : slot_plus2;

        // A stop that lands on a period boundary ends without starting a new period.
        stop_now = (slot_reg == '0) && ((state_reg == ST_DRAIN) || !EN);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_reg      <= ST_IDLE;
            slot_reg       <= '0;
            half_reg       <= CNT_W'(DEFAULT_HALF);
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            ddr_reg        <= 2'b00;
            running_reg    <= 1'b0;
            rise_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            err_reg  <= cfg_xfer && cfg_zero;
            rise_reg <= 1'b0;
            if (cfg_hold) begin
                pend_reg       <= CFG_HALF;
                pend_valid_reg <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    half_reg       <= half_eff;
                    pend_valid_reg <= 1'b0;
                    ddr_reg        <= 2'b00;
                    if (EN) begin
                        state_reg   <= ST_RUN;
                        ddr_reg     <= beat;
                        rise_reg    <= 1'b1;
                        slot_reg    <= slot_adv;
                        running_reg <= 1'b1;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (stop_now) begin
                        state_reg   <= ST_IDLE;
                        ddr_reg     <= 2'b00;
                        running_reg <= 1'b0;
                    end else begin
                        ddr_reg  <= beat;
                        rise_reg <= (slot_reg == '0);
                        slot_reg <= slot_adv;
                        if (state_reg == ST_RUN && !EN)
                            state_reg <= ST_DRAIN;
                        if (wrap && pend_valid_reg) begin
                            half_reg       <= pend_reg;
                            pend_valid_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    slot_reg    <= '0;
                    ddr_reg     <= 2'b00;
                    running_reg <= 1'b0;
                end
            endcase
        end
    end

    assign DDR_OUT   = ddr_reg;
    assign RUNNING   = running_reg;
    assign RISE_TICK = rise_reg;
    assign CFG_ERR   = err_reg;
    assign CFG_READY = !pend_valid_reg;

endmodule

// File: tb/tb_xcvr_ref_clk_fwd.sv
// Directed bench for xcvr_ref_clk_fwd: outputs sampled on the falling edge and compared
// against hand-computed beat sequences.
module tb_xcvr_ref_clk_fwd;
    logic       CLK = 1'b0;
    logic       RESETN;
    logic       EN;
    logic       CFG_VALID;
    logic [7:0] CFG_HALF;
    logic       CFG_READY;
    logic       CFG_ERR;
    logic [1:0] DDR_OUT;
    logic       RUNNING;
    logic       RISE_TICK;

    int total = 0;
    int bad   = 0;

    xcvr_ref_clk_fwd #(.CNT_W(8), .DEFAULT_HALF(4)) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .EN        (EN),
        .CFG_VALID (CFG_VALID),
        .CFG_HALF  (CFG_HALF),
        .CFG_READY (CFG_READY),
        .CFG_ERR   (CFG_ERR),
        .DDR_OUT   (DDR_OUT),
        .RUNNING   (RUNNING),
        .RISE_TICK (RISE_TICK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] ddr, input logic rise, input logic run);
        chk({tag, ".ddr"}, 32'(DDR_OUT), 32'(ddr));
        chk({tag, ".rise"}, 32'(RISE_TICK), 32'(rise));
        chk({tag, ".run"}, 32'(RUNNING), 32'(run));
        $display("%0t %s ddr=%b rise=%b run=%b rdy=%b err=%b", $time, tag, DDR_OUT, RISE_TICK,
                 RUNNING, CFG_READY, CFG_ERR);
    endtask

    // One config transfer while IDLE; leaves inputs settled right after a falling edge.
    task automatic cfg_set(input logic [7:0] h);
        CFG_VALID = 1'b1;
        CFG_HALF  = h;
        @(negedge CLK);
        CFG_VALID = 1'b0;
        chk($sformatf("cfg%0d.ready", h), 32'(CFG_READY), 32'd1);
    endtask

    initial begin
        RESETN    = 1'b0;
        EN        = 1'b0;
        CFG_VALID = 1'b0;
        CFG_HALF  = 8'd0;
        #1;
        chk_out("reset", 2'b00, 1'b0, 1'b0);
        chk("reset.ready", 32'(CFG_READY), 32'd1);
        chk("reset.err", 32'(CFG_ERR), 32'd0);
        @(negedge CLK);
        RESETN = 1'b1;

        // H=1: 01 every cycle with a rise tick each cycle
        cfg_set(8'd1);
        EN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk_out($sformatf("h1.b%0d", i), 2'b01, 1'b1, 1'b1);
        end
        EN = 1'b0;
        @(negedge CLK);
        chk_out("h1.stop", 2'b00, 1'b0, 1'b0);

        // H=3: 11,01,00 repeating; stop on the boundary gives no partial period
        cfg_set(8'd3);
        EN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            case (i % 3)
                0:       chk_out($sformatf("h3.b%0d", i), 2'b11, 1'b1, 1'b1);
                1:       chk_out($sformatf("h3.b%0d", i), 2'b01, 1'b0, 1'b1);
                default: chk_out($sformatf("h3.b%0d", i), 2'b00, 1'b0, 1'b1);
            endcase
        end
        EN = 1'b0;
        @(negedge CLK);
        chk_out("h3.stop", 2'b00, 1'b0, 1'b0);

        // H=2 running, reprogram to 5 mid-period
        cfg_set(8'd2);
        EN = 1'b1;
        @(negedge CLK);
        chk_out("h2.b0", 2'b11, 1'b1, 1'b1);
        @(negedge CLK);
        chk_out("h2.b1", 2'b00, 1'b0, 1'b1);
        CFG_VALID = 1'b1;
        CFG_HALF  = 8'd5;
        @(negedge CLK);
        CFG_VALID = 1'b0;
        chk_out("h2.b2", 2'b11, 1'b1, 1'b1);
        chk("h2.b2.ready", 32'(CFG_READY), 32'd0);
        @(negedge CLK);
        chk_out("h2.b3", 2'b00, 1'b0, 1'b1);
        chk("h2.b3.ready", 32'(CFG_READY), 32'd1);
        @(negedge CLK);
        chk_out("h5.b0", 2'b11, 1'b1, 1'b1);
        @(negedge CLK);
        chk_out("h5.b1", 2'b11, 1'b0, 1'b1);
        @(negedge CLK);
        chk_out("h5.b2", 2'b01, 1'b0, 1'b1);
        @(negedge CLK);
        chk_out("h5.b3", 2'b00, 1'b0, 1'b1);
        @(negedge CLK);
        chk_out("h5.b4", 2'b00, 1'b0, 1'b1);
        EN = 1'b0;
        @(negedge CLK);
        chk_out("h5.stop", 2'b00, 1'b0, 1'b0);

        // H=4: stop during first high beat, re-raise EN during drain
        cfg_set(8'd4);
        EN = 1'b1;
        @(negedge CLK);
        chk_out("h4.b0", 2'b11, 1'b1, 1'b1);
        EN = 1'b0;
        @(negedge CLK);
        chk_out("h4.d1", 2'b11, 1'b0, 1'b1);
        EN = 1'b1;
        @(negedge CLK);
        chk_out("h4.d2", 2'b00, 1'b0, 1'b1);
        @(negedge CLK);
        chk_out("h4.d3", 2'b00, 1'b0, 1'b1);
        @(negedge CLK);
        chk_out("h4.idle", 2'b00, 1'b0, 1'b0);
        @(negedge CLK);
        chk_out("h4.restart", 2'b11, 1'b1, 1'b1);

        // zero half-period is dropped with a one-cycle error pulse
        CFG_VALID = 1'b1;
        CFG_HALF  = 8'd0;
        EN        = 1'b0;
        @(negedge CLK);
        CFG_VALID = 1'b0;
        chk_out("zero.b1", 2'b11, 1'b0, 1'b1);
        chk("zero.err", 32'(CFG_ERR), 32'd1);
        chk("zero.ready", 32'(CFG_READY), 32'd1);
        @(negedge CLK);
        chk_out("zero.b2", 2'b00, 1'b0, 1'b1);
        chk("zero.err_clr", 32'(CFG_ERR), 32'd0);
        @(negedge CLK);
        chk_out("zero.b3", 2'b00, 1'b0, 1'b1);
        @(negedge CLK);
        chk_out("zero.idle", 2'b00, 1'b0, 0);

        // async reset mid-high beat, then restart at the default half-period
        cfg_set(8'd2);
        EN = 1'b1;
        @(negedge CLK);
        chk_out("rst.pre", 2'b11, 1'b1, 1'b1);
        #2;
        RESETN = 1'b0;
        #1;
        chk_out("rst.async", 2'b00, 1'b0, 1'b0);
        chk("rst.ready", 32'(CFG_READY), 32'd1);
        @(negedge CLK);
        RESETN = 1'b1;
        @(negedge CLK);
        chk_out("rst.b0", 2'b11, 1'b1, 1'b1);
        @(negedge CLK);
        chk_out("rst.b1", 2'b11, 1'b0, 1'b1);
        @(negedge CLK);
        chk_out("rst.b2", 2'b00, 1'b0, 1'b1);
        @(negedge CLK);
        chk_out("rst.b3", 2'b00, 1'b0, 1'b1);
        @(negedge CLK);
        chk_out("rst.b4", 2'b11, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
